// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants, enable encodings and arbiter state type for the
// memory-port arbiter.
package mem_port_arbiter_pkg;

    localparam int CORE_COUNT = 4;
    localparam int CORE_ID_W  = 2;
    localparam int REG_WIDTH  = 8;

    localparam logic [1:0] EN_IDLE = 2'b00;
    localparam logic [1:0] EN_LD   = 2'b01;
    localparam logic [1:0] EN_ST   = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // 2'b11 is deliberately not a request.
    function automatic logic is_req(input logic [1:0] en);
        return (en == EN_LD) || (en == EN_ST);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// rr_ptr, wrapping modulo CORE_COUNT.
module mem_port_arbiter_rr_pick #(
    parameter int CORE_COUNT = 4,
    parameter int IDX_W      = 2
) (
    input  logic [CORE_COUNT-1:0] req,
    input  logic [IDX_W-1:0]      rr_ptr,
    output logic                  valid,
    output logic [IDX_W-1:0]      index
);

    function automatic int wrap_index(input int base, input int k);
        return (base + k) % CORE_COUNT;
    endfunction

    // Scan from the farthest offset down so the nearest match is written last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = CORE_COUNT - 1; k >= 0; k--) begin
            if (req[wrap_index(int'(rr_ptr), k)]) begin
                valid = 1'b1;
                index = IDX_W'(wrap_index(int'(rr_ptr), k));
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port among CORE_COUNT cores,
// with per-access watchdog abort and sticky timeout flag.
module mem_port_arbiter #(
    parameter int CORE_COUNT   = mem_port_arbiter_pkg::CORE_COUNT,
    parameter int REG_WIDTH    = mem_port_arbiter_pkg::REG_WIDTH,
    parameter int CORE_ID_W    = mem_port_arbiter_pkg::CORE_ID_W,
    parameter int TIMEOUT      = 255,
    localparam int ADDR_WIDTH  = CORE_ID_W + REG_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2*CORE_COUNT-1:0]          enable_M,
    input  logic [ADDR_WIDTH*CORE_COUNT-1:0] addr_M,
    input  logic [REG_WIDTH*CORE_COUNT-1:0]  wr_data_M,
    output logic [REG_WIDTH*CORE_COUNT-1:0]  rd_data_M,
    output logic [CORE_COUNT-1:0]            ready_M,
    output logic [1:0]                       mem_enable,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [REG_WIDTH-1:0]             mem_wr_data,
    input  logic [REG_WIDTH-1:0]             mem_rd_data,
    input  logic                             mem_ready,
    output logic                             timeout_err
);
    import mem_port_arbiter_pkg::*;

    localparam int IDX_W  = $clog2(CORE_COUNT);
    localparam int WDOG_W = 8;

    arb_state_t            state;
    arb_state_t            state_next;
    logic [IDX_W-1:0]      grant;
    logic [IDX_W-1:0]      grant_inc;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      pick_index;
    logic                  pick_valid;
    logic [WDOG_W-1:0]     wdog;
    logic [CORE_COUNT-1:0] req;
    logic                  start;
    logic                  finish;
    logic                  abort;

    always_comb begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            req[i] = is_req(enable_M[2*i +: 2]);
        end
    end

    mem_port_arbiter_rr_pick #(
        .CORE_COUNT (CORE_COUNT),
        .IDX_W      (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .index  (pick_index)
    );

    assign grant_inc = (grant == IDX_W'(CORE_COUNT - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Completion lanes are driven straight from mem_ready so the core sees
    // ready_M in the same cycle the memory finishes.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        ready_M    = '0;
        rd_data_M  = '0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    start      = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    finish         = 1'b1;
                    ready_M[grant] = 1'b1;
                    if (mem_enable == EN_LD) begin
                        rd_data_M[REG_WIDTH*grant +: REG_WIDTH] = mem_rd_data;
                    end
                    state_next = ST_IDLE;
                end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
                    finish         = 1'b1;
                    abort          = 1'b1;
                    ready_M[grant] = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant       <= '0;
            rr_ptr      <= '0;
            wdog        <= '0;
            mem_enable  <= EN_IDLE;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (start) begin
                grant       <= pick_index;
                mem_enable  <= enable_M[2*pick_index +: 2];
                mem_addr    <= addr_M[ADDR_WIDTH*pick_index +: ADDR_WIDTH];
                mem_wr_data <= wr_data_M[REG_WIDTH*pick_index +: REG_WIDTH];
                wdog        <= '0;
            end else if (finish) begin
                rr_ptr     <= grant_inc;
                mem_enable <= EN_IDLE;
                wdog       <= '0;
                if (abort) begin
                    timeout_err <= 1'b1;
                end
            end else if (state == ST_BUSY) begin
                wdog <= wdog + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: a transaction-level
// arbitration model predicts memory requests and core completions.
module tb_mem_port_arbiter;

    localparam int N    = 4;
    localparam int RW   = 8;
    localparam int IDW  = 2;
    localparam int AW   = IDW + RW;
    localparam int TO   = 4;
    localparam int HANG = 100;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [2*N-1:0]  enable_M = '0;
    logic [AW*N-1:0] addr_M = '0;
    logic [RW*N-1:0] wr_data_M = '0;
    logic [RW*N-1:0] rd_data_M;
    logic [N-1:0]    ready_M;
    logic [1:0]      mem_enable;
    logic [AW-1:0]   mem_addr;
    logic [RW-1:0]   mem_wr_data;
    logic [RW-1:0]   mem_rd_data;
    logic            mem_ready;
    logic            timeout_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .CORE_COUNT (N),
        .REG_WIDTH  (RW),
        .CORE_ID_W  (IDW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_M    (enable_M),
        .addr_M      (addr_M),
        .wr_data_M   (wr_data_M),
        .rd_data_M   (rd_data_M),
        .ready_M     (ready_M),
        .mem_enable  (mem_enable),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_ready   (mem_ready),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [1:0]    en;
        logic [AW-1:0] addr;
        logic [RW-1:0] wd;
        int            wcyc;
    } mreq_t;

    typedef struct {
        int            core;
        logic [RW-1:0] data;
        bit            tmo;
        int            cyc;
    } resp_t;

    mreq_t         mq[$];
    resp_t         rq[$];
    logic [RW-1:0] mem_array [0:(1<<AW)-1];
    logic [RW-1:0] shadow    [0:(1<<AW)-1];
    int            passed = 0;
    int            total = 0;
    int            cyc = 0;
    int            mode = 0;
    int            done_cnt [N];
    int            seen [N];
    bit            holding [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic flag_fail(input string name);
        total++;
        $display("FAIL %s: got an unpredicted event, required none (t=%0t)", name, $time);
    endtask

    // 0: zero-wait memory, 1: memory never answers, 2: random waits with occasional hangs
    function automatic int plan_wait();
        if (mode == 0) return 0;
        if (mode == 1) return HANG;
        if ($urandom_range(0, 19) == 0) return HANG;
        return $urandom_range(0, TO - 1);
    endfunction

    // Reference model: one access at a time, round-robin from the core after the last one served.
    initial begin : model
        bit            busy;
        int            left;
        int            rr;
        int            g;
        int            c;
        int            w;
        int            dur;
        mreq_t         m;
        resp_t         r;
        busy = 0; left = 0; rr = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                busy = 0; left = 0; rr = 0;
                mq.delete();
                rq.delete();
            end else if (busy) begin
                left--;
                if (left == 0) busy = 0;
            end else begin
                g = -1;
                for (int k = 0; k < N; k++) begin
                    c = (rr + k) % N;
                    if (g < 0 && (enable_M[2*c +: 2] == 2'b01 || enable_M[2*c +: 2] == 2'b10)) g = c;
                end
                if (g >= 0) begin
                    m.en   = enable_M[2*g +: 2];
                    m.addr = addr_M[AW*g +: AW];
                    m.wd   = wr_data_M[RW*g +: RW];
                    w      = plan_wait();
                    m.wcyc = w;
                    r.core = g;
                    r.tmo  = (w >= TO);
                    dur    = r.tmo ? TO : w + 1;
                    r.cyc  = cyc + dur - 1;
                    r.data = (m.en == 2'b01 && !r.tmo) ? shadow[m.addr] : '0;
                    if (m.en == 2'b10 && !r.tmo) shadow[m.addr] = m.wd;
                    mq.push_back(m);
                    rq.push_back(r);
                    busy = 1; left = dur; rr = (g + 1) % N;
                end
            end
        end
    end

    // Memory: checks each request against the model and answers after its planned wait.
    initial begin : responder
        bit    active;
        int    left;
        mreq_t cur;
        active = 0; left = 0;
        cur.en = '0; cur.addr = '0; cur.wd = '0; cur.wcyc = 0;
        mem_ready = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(negedge clk);
            mem_ready   = 1'b0;
            mem_rd_data = RW'($urandom);
            if (!reset) begin
                active = 0;
            end else if (mem_enable == 2'b00) begin
                active = 0;
                if ($urandom_range(0, 7) == 0) mem_ready = 1'b1;
            end else begin
                if (!active) begin
                    if (mq.size() == 0) begin
                        flag_fail("mem_unexpected_request");
                        left = HANG;
                    end else begin
                        cur = mq.pop_front();
                        check("mem_enable", 32'(mem_enable), 32'(cur.en));
                        check("mem_addr", 32'(mem_addr), 32'(cur.addr));
                        check("mem_wr_data", 32'(mem_wr_data), 32'(cur.wd));
                        left = cur.wcyc;
                    end
                    active = 1;
                end else begin
                    check("mem_hold", 32'({mem_enable, mem_addr, mem_wr_data}),
                          32'({cur.en, cur.addr, cur.wd}));
                end
                if (left == 0) begin
                    mem_ready = 1'b1;
                    if (mem_enable == 2'b01) mem_rd_data = mem_array[mem_addr];
                    else if (mem_enable == 2'b10) mem_array[mem_addr] = mem_wr_data;
                end else begin
                    left--;
                end
            end
        end
    end

    initial begin : monitor
        bit            exp_err;
        resp_t         r;
        logic [RW*N-1:0] ev;
        logic [N-1:0]  el;
        exp_err = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                exp_err = 0;
            end else begin
                check("timeout_err", 32'(timeout_err), 32'(exp_err));
                if (ready_M != '0) begin
                    if (rq.size() == 0) begin
                        flag_fail("unexpected_ready");
                    end else begin
                        r  = rq.pop_front();
                        el = '0;
                        el[r.core] = 1'b1;
                        ev = '0;
                        ev[RW*r.core +: RW] = r.data;
                        check("ready_lane", 32'(ready_M), 32'(el));
                        check("ready_cycle", 32'(cyc), 32'(r.cyc));
                        check("rd_data", 32'(rd_data_M), 32'(ev));
                        if (r.tmo) exp_err = 1;
                        done_cnt[r.core]++;
                    end
                end else begin
                    check("rd_data_idle", 32'(rd_data_M), 32'h0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        enable_M = '0;
        for (int i = 0; i < N; i++) begin
            holding[i] = 0;
            seen[i] = done_cnt[i];
        end
    endtask

    task automatic drive(input int core, input logic [1:0] en, input logic [AW-1:0] a, input logic [RW-1:0] d);
        enable_M[2*core +: 2]   = en;
        addr_M[AW*core +: AW]   = a;
        wr_data_M[RW*core +: RW] = d;
        holding[core] = (en == 2'b01 || en == 2'b10);
    endtask

    // Cores hold a request until their completion pulse, sometimes give up, sometimes drive 11.
    task automatic rand_cycle(input int p_new, input int p_inv, input int p_drop);
        for (int i = 0; i < N; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (done_cnt[i] != seen[i]) begin
                seen[i] = done_cnt[i];
                holding[i] = 0;
                enable_M[2*i +: 2] = 2'b00;
            end else if (holding[i]) begin
                if (r < p_drop) begin
                    holding[i] = 0;
                    enable_M[2*i +: 2] = 2'b00;
                end
            end else if (r < p_new) begin
                drive(i, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10,
                      AW'($urandom_range(0, 15)), RW'($urandom));
            end else if (r < p_new + p_inv) begin
                enable_M[2*i +: 2] = 2'b11;
            end else begin
                enable_M[2*i +: 2] = 2'b00;
            end
        end
    endtask

    task automatic do_reset(input bit expect_idle);
        step();
        if (expect_idle) check("pending_before_reset", 32'(rq.size()), 32'h0);
        reset = 1'b0;
        release_all();
        #1;
        check("rst_ready_M", 32'(ready_M), 32'h0);
        check("rst_mem_enable", 32'(mem_enable), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wr_data", 32'(mem_wr_data), 32'h0);
        check("rst_rd_data", 32'(rd_data_M), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        repeat (2) step();
        reset = 1'b1;
    endtask

    initial begin : stimulus
        logic [RW-1:0] v;
        for (int i = 0; i < (1 << AW); i++) begin
            v = RW'($urandom);
            mem_array[i] = v;
            shadow[i] = v;
        end
        for (int i = 0; i < N; i++) begin
            done_cnt[i] = 0;
            seen[i] = 0;
            holding[i] = 0;
        end
        #1 reset = 1'b0;
        #1;
        check("init_mem_enable", 32'(mem_enable), 32'h0);
        check("init_ready_M", 32'(ready_M), 32'h0);
        check("init_timeout_err", 32'(timeout_err), 32'h0);
        repeat (2) step();
        reset = 1'b1;

        // Single zero-wait load from core 1
        mode = 0;
        mem_array[10'h105] = 8'hA5;
        shadow[10'h105] = 8'hA5;
        step();
        drive(1, 2'b01, 10'h105, 8'h00);
        step();
        #2;
        check("t1_mem_enable", 32'(mem_enable), 32'h1);
        check("t1_mem_addr", 32'(mem_addr), 32'h105);
        repeat (5) begin step(); rand_cycle(0, 0, 0); end

        // Three simultaneous stores from a fresh round-robin pointer
        do_reset(1);
        step();
        drive(0, 2'b10, 10'h011, 8'h3C);
        drive(2, 2'b10, 10'h012, 8'hC3);
        drive(3, 2'b10, 10'h011, 8'h5A);
        repeat (12) begin step(); rand_cycle(0, 0, 0); end

        // Cores 0 and 1 hold loads continuously
        drive(0, 2'b01, 10'h011, 8'h00);
        drive(1, 2'b01, 10'h012, 8'h00);
        repeat (12) step();
        release_all();
        repeat (4) step();

        // Encoding 11 is never a request
        enable_M[5:4] = 2'b11;
        repeat (8) begin
            step();
            #2;
            check("inv_no_grant", 32'(mem_enable), 32'h0);
        end
        release_all();

        // Memory never answers: watchdog abort
        mode = 1;
        step();
        drive(3, 2'b01, 10'h033, 8'h00);
        repeat (10) begin step(); rand_cycle(0, 0, 0); end
        #2;
        check("timeout_err_sticky", 32'(timeout_err), 32'h1);

        // Reset in the middle of a hung access, then normal service
        do_reset(1);
        step();
        drive(0, 2'b10, 10'h044, 8'h77);
        step();
        do_reset(0);
        mode = 0;
        step();
        drive(1, 2'b01, 10'h044, 8'h00);
        repeat (6) begin step(); rand_cycle(0, 0, 0); end

        // Random traffic
        mode = 2;
        repeat (3000) begin step(); rand_cycle(25, 3, 2); end

        release_all();
        for (int k = 0; k < 200 && (rq.size() + mq.size()) != 0; k++) step();
        repeat (3) step();
        check("drain_pending", 32'(rq.size() + mq.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
